cheri_lsu_stkz_arb: RTL and testbench

//  Shares the single data-side LSU request port between the core load/store path and the

---
 rtl/cheri_lsu_stkz_arb.sv | 160 ++++++++++++++++
 tb/tb_cheri_lsu_stkz_arb.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cheri_lsu_stkz_arb.sv
// Arbiter sharing the data-side LSU port between the core and the stack-zeroization engine.
// Grants are held until the LSU accepts; an owner FIFO routes in-order responses back.
module cheri_lsu_stkz_arb #(
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned StarveMax      = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic        core_is_cap_i,
  input  logic [31:0] core_addr_i,
  input  logic [32:0] core_wdata_i,
  output logic        core_req_done_o,
  output logic        core_resp_valid_o,
  output logic        core_resp_err_o,
  input  logic        stkz_req_i,
  input  logic        stkz_we_i,
  input  logic        stkz_is_cap_i,
  input  logic [31:0] stkz_addr_i,
  input  logic [32:0] stkz_wdata_i,
  output logic        stkz_req_done_o,
  output logic        stkz_resp_valid_o,
  output logic        stkz_resp_err_o,
  output logic        lsu_req_o,
  output logic        lsu_we_o,
  output logic        lsu_is_cap_o,
  output logic [31:0] lsu_addr_o,
  output logic [32:0] lsu_wdata_o,
  input  logic        lsu_req_done_i,
  input  logic        lsu_resp_valid_i,
  input  logic        lsu_resp_err_i,
  output logic        spurious_resp_o
);

  // state     | meaning
  // IDLE      | no grant held; arbitrate each cycle
  // LOCK_CORE | core granted, waiting for LSU accept
  // LOCK_STKZ | stkz granted, waiting for LSU accept (or stkz abort)
  typedef enum logic [1:0] {IDLE, LOCK_CORE, LOCK_STKZ} state_e;

  localparam int unsigned PtrW = (MaxOutstanding > 2) ? 2 : 1;
  localparam int unsigned CntW = 3;
  localparam int unsigned SW   = (StarveMax > 1) ? $clog2(StarveMax + 1) : 1;

  state_e                    state_q, state_d;
  logic [MaxOutstanding-1:0] owner_q, owner_d;  // 1 = stkz owns the slot
  logic [PtrW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic [SW-1:0]             starve_q, starve_d;
  logic                      spur_q, spur_d;

  logic grant, sel_stkz, push, pop, head, fifo_full, fifo_empty, starved;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fifo_full  = (cnt_q == CntW'(MaxOutstanding));
  assign fifo_empty = (cnt_q == '0);
  assign starved    = (starve_q >= SW'(StarveMax));

  always_comb begin
    grant    = 1'b0;
    sel_stkz = 1'b0;
    state_d  = state_q;
    unique case (state_q)
      IDLE: begin
        if (!fifo_full) begin
          if (stkz_req_i && (!core_req_i || starved)) begin
            grant    = 1'b1;
            sel_stkz = 1'b1;
          end else if (core_req_i) begin
            grant = 1'b1;
          end
        end
        if (grant && !lsu_req_done_i) state_d = sel_stkz ? LOCK_STKZ : LOCK_CORE;
      end
      LOCK_CORE: begin
        grant = core_req_i;
        if (lsu_req_done_i || !core_req_i) state_d = IDLE;
      end
      LOCK_STKZ: begin
        sel_stkz = 1'b1;
        grant    = stkz_req_i;
        if (lsu_req_done_i || !stkz_req_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign push = grant & lsu_req_done_i;
  assign pop  = lsu_resp_valid_i & ~fifo_empty;
  assign head = owner_q[rd_ptr_q];

  always_comb begin
    owner_d  = owner_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      owner_d[wr_ptr_q] = sel_stkz;
      wr_ptr_d          = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Starvation only counts while stkz is actually waiting.
  always_comb begin
    starve_d = starve_q;
    if (!stkz_req_i)             starve_d = '0;
    else if (push && sel_stkz)   starve_d = '0;
    else if (push && !starved)   starve_d = starve_q + 1'b1;
  end

  assign spur_d = spur_q | (lsu_resp_valid_i & fifo_empty);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
      spur_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      spur_q   <= spur_d;
    end
  end

  assign lsu_req_o    = grant;
  assign lsu_we_o     = grant & (sel_stkz ? stkz_we_i : core_we_i);
  assign lsu_is_cap_o = grant & (sel_stkz ? stkz_is_cap_i : core_is_cap_i);
  assign lsu_addr_o   = grant ? (sel_stkz ? stkz_addr_i : core_addr_i) : '0;
  assign lsu_wdata_o  = grant ? (sel_stkz ? stkz_wdata_i : core_wdata_i) : '0;

  assign core_req_done_o   = push & ~sel_stkz;
  assign stkz_req_done_o   = push & sel_stkz;
  assign core_resp_valid_o = pop & ~head;
  assign stkz_resp_valid_o = pop & head;
  assign core_resp_err_o   = pop & ~head & lsu_resp_err_i;
  assign stkz_resp_err_o   = pop & head & lsu_resp_err_i;
  assign spurious_resp_o   = spur_q;

  lock_core_held_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == LOCK_CORE) |-> core_req_i);

endmodule

// File: tb/tb_cheri_lsu_stkz_arb.sv
// Randomized and directed bench for cheri_lsu_stkz_arb against a queue-based reference model.
module tb_cheri_lsu_stkz_arb;
  localparam int MO = 2;
  localparam int SM = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        core_req_i, core_we_i, core_is_cap_i;
  logic [31:0] core_addr_i;
  logic [32:0] core_wdata_i;
  logic        core_req_done_o, core_resp_valid_o, core_resp_err_o;
  logic        stkz_req_i, stkz_we_i, stkz_is_cap_i;
  logic [31:0] stkz_addr_i;
  logic [32:0] stkz_wdata_i;
  logic        stkz_req_done_o, stkz_resp_valid_o, stkz_resp_err_o;
  logic        lsu_req_o, lsu_we_o, lsu_is_cap_o;
  logic [31:0] lsu_addr_o;
  logic [32:0] lsu_wdata_o;
  logic        lsu_req_done_i, lsu_resp_valid_i, lsu_resp_err_i;
  logic        spurious_resp_o;

  cheri_lsu_stkz_arb #(.MaxOutstanding(MO), .StarveMax(SM)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .core_req_i(core_req_i), .core_we_i(core_we_i), .core_is_cap_i(core_is_cap_i),
    .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i),
    .core_req_done_o(core_req_done_o), .core_resp_valid_o(core_resp_valid_o),
    .core_resp_err_o(core_resp_err_o),
    .stkz_req_i(stkz_req_i), .stkz_we_i(stkz_we_i), .stkz_is_cap_i(stkz_is_cap_i),
    .stkz_addr_i(stkz_addr_i), .stkz_wdata_i(stkz_wdata_i),
    .stkz_req_done_o(stkz_req_done_o), .stkz_resp_valid_o(stkz_resp_valid_o),
    .stkz_resp_err_o(stkz_resp_err_o),
    .lsu_req_o(lsu_req_o), .lsu_we_o(lsu_we_o), .lsu_is_cap_o(lsu_is_cap_o),
    .lsu_addr_o(lsu_addr_o), .lsu_wdata_o(lsu_wdata_o),
    .lsu_req_done_i(lsu_req_done_i), .lsu_resp_valid_i(lsu_resp_valid_i),
    .lsu_resp_err_i(lsu_resp_err_i), .spurious_resp_o(spurious_resp_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Reference model: queue of owners (1 = stkz), held grant (0 none, 1 core, 2 stkz).
  bit mq[$];
  int mlock;
  int mstarve;
  bit mspur;

  function automatic void mdl_eval(output bit g, output bit s);
    g = 1'b0;
    s = 1'b0;
    if (mlock == 1) g = core_req_i;
    else if (mlock == 2) begin
      g = stkz_req_i;
      s = 1'b1;
    end else if (mq.size() < MO) begin
      if (stkz_req_i && (!core_req_i || mstarve >= SM)) begin
        g = 1'b1;
        s = 1'b1;
      end else if (core_req_i) g = 1'b1;
    end
  endfunction

  task automatic tick();
    bit g, s, rv, dn, sr;
    mdl_eval(g, s);
    rv = lsu_resp_valid_i;
    dn = lsu_req_done_i;
    sr = stkz_req_i;
    @(posedge clk_i);
    if (rv) begin
      if (mq.size() == 0) mspur = 1'b1;
      else void'(mq.pop_front());
    end
    if (g && dn) mq.push_back(s);
    if (!sr) mstarve = 0;
    else if (g && dn) mstarve = s ? 0 : ((mstarve < SM) ? mstarve + 1 : mstarve);
    mlock = (g && !dn) ? (s ? 2 : 1) : 0;
    #1;
  endtask

  task automatic set_in(input bit creq, input bit sreq, input bit dn, input bit rv, input bit er);
    core_req_i       = creq;
    stkz_req_i       = sreq;
    lsu_req_done_i   = dn;
    lsu_resp_valid_i = rv;
    lsu_resp_err_i   = er;
  endtask

  task automatic clear_inputs();
    set_in(0, 0, 0, 0, 0);
    core_we_i = 0; core_is_cap_i = 0; core_addr_i = '0; core_wdata_i = '0;
    stkz_we_i = 0; stkz_is_cap_i = 0; stkz_addr_i = '0; stkz_wdata_i = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_ni = 1'b0;
    mq.delete();
    mlock = 0; mstarve = 0; mspur = 0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  task automatic drain();
    set_in(0, 0, 0, 1, 0);
    for (int k = 0; k < 8 && mq.size() > 0; k++) tick();
    lsu_resp_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [9:0] act;
    clear_inputs();
    rst_ni = 1'b0;
    mq.delete();
    mlock = 0; mstarve = 0; mspur = 0;
    lsu_resp_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    act = {lsu_req_o, lsu_we_o, lsu_is_cap_o, core_req_done_o, stkz_req_done_o,
           core_resp_valid_o, core_resp_err_o, stkz_resp_valid_o, stkz_resp_err_o, spurious_resp_o};
    total++;
    if (act !== 10'b0) begin
      bad++; $display("FAIL reset_outputs: got %b want 0", act);
    end
    total++;
    if (lsu_addr_o !== 32'h0 || lsu_wdata_o !== 33'h0) begin
      bad++; $display("FAIL reset_bus: got %h/%h want 0", lsu_addr_o, lsu_wdata_o);
    end
    lsu_resp_valid_i = 1'b0;
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    core_req_i = 1'b1;
    #1;
    total++;
    if (lsu_req_o !== 1'b1) begin
      bad++; $display("FAIL reset_idle_grant: got %b want 1", lsu_req_o);
    end
    core_req_i = 1'b0;
  endtask

  task automatic test_core_only();
    logic [31:0] a;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      a = $urandom();
      core_addr_i = a;
      core_we_i   = i[0];
      set_in(1, 0, 1, 0, 0);
      #1;
      total++;
      if (core_req_done_o !== 1'b1 || stkz_req_done_o !== 1'b0 || lsu_addr_o !== a) begin
        bad++; $display("FAIL core_only_done: got done=%b sdone=%b addr=%h want 1 0 %h",
                        core_req_done_o, stkz_req_done_o, lsu_addr_o, a);
      end
      tick();
      set_in(0, 0, 0, 1, i == 1);
      #1;
      total++;
      if (core_resp_valid_o !== 1'b1 || core_resp_err_o !== (i == 1) || stkz_resp_valid_o !== 1'b0) begin
        bad++; $display("FAIL core_only_resp: got v=%b e=%b sv=%b want 1 %b 0",
                        core_resp_valid_o, core_resp_err_o, stkz_resp_valid_o, i == 1);
      end
      tick();
    end
    lsu_resp_valid_i = 1'b0;
  endtask

  task automatic test_starve();
    bit es;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      set_in(1, 1, 1, i > 0, 0);
      #1;
      es = (i % 5 == 4);
      total++;
      if (stkz_req_done_o !== es || core_req_done_o !== !es) begin
        bad++; $display("FAIL starve_pattern[%0d]: got c=%b s=%b want c=%b s=%b",
                        i, core_req_done_o, stkz_req_done_o, !es, es);
      end
      tick();
    end
    drain();
  endtask

  task automatic test_lock_stkz();
    do_reset();
    stkz_addr_i = 32'h0000_1FF8;
    core_addr_i = 32'h0000_00A0;
    for (int c = 0; c < 4; c++) begin
      set_in(c > 0, 1, c == 3, 0, 0);
      #1;
      total++;
      if (lsu_addr_o !== 32'h0000_1FF8 || stkz_req_done_o !== (c == 3) || core_req_done_o !== 1'b0) begin
        bad++; $display("FAIL lock_stkz[%0d]: got addr=%h sdone=%b cdone=%b want 1ff8 %b 0",
                        c, lsu_addr_o, stkz_req_done_o, core_req_done_o, c == 3);
      end
      tick();
    end
    set_in(1, 0, 1, 0, 0);
    #1;
    total++;
    if (core_req_done_o !== 1'b1 || lsu_addr_o !== 32'h0000_00A0) begin
      bad++; $display("FAIL lock_core_after: got cdone=%b addr=%h want 1 a0", core_req_done_o, lsu_addr_o);
    end
    tick();
    set_in(0, 0, 0, 1, 0);
    #1;
    total++;
    if (stkz_resp_valid_o !== 1'b1 || core_resp_valid_o !== 1'b0) begin
      bad++; $display("FAIL lock_resp1: got s=%b c=%b want 1 0", stkz_resp_valid_o, core_resp_valid_o);
    end
    tick();
    #1;
    total++;
    if (core_resp_valid_o !== 1'b1 || stkz_resp_valid_o !== 1'b0) begin
      bad++; $display("FAIL lock_resp2: got c=%b s=%b want 1 0", core_resp_valid_o, stkz_resp_valid_o);
    end
    tick();
    lsu_resp_valid_i = 1'b0;
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      set_in(1, 0, 1, 0, 0);
      #1;
      total++;
      if (core_req_done_o !== 1'b1) begin
        bad++; $display("FAIL full_fill[%0d]: got %b want 1", i, core_req_done_o);
      end
      tick();
    end
    set_in(1, 0, 0, 0, 0);
    #1;
    total++;
    if (lsu_req_o !== 1'b0) begin
      bad++; $display("FAIL full_block: got lsu_req=%b want 0", lsu_req_o);
    end
    tick();
    set_in(1, 0, 0, 1, 0);
    #1;
    total++;
    if (lsu_req_o !== 1'b0 || core_resp_valid_o !== 1'b1) begin
      bad++; $display("FAIL full_pop_same: got req=%b rv=%b want 0 1", lsu_req_o, core_resp_valid_o);
    end
    tick();
    set_in(1, 0, 1, 1, 0);
    #1;
    total++;
    if (lsu_req_o !== 1'b1 || core_req_done_o !== 1'b1 || core_resp_valid_o !== 1'b1) begin
      bad++; $display("FAIL full_regrant: got req=%b done=%b rv=%b want 1 1 1",
                      lsu_req_o, core_req_done_o, core_resp_valid_o);
    end
    tick();
    drain();
  endtask

  task automatic test_interleave();
    do_reset();
    set_in(1, 0, 1, 0, 0); tick();
    set_in(0, 1, 1, 0, 0);
    #1;
    total++;
    if (stkz_req_done_o !== 1'b1) begin
      bad++; $display("FAIL inter_stkz_push: got %b want 1", stkz_req_done_o);
    end
    tick();
    set_in(0, 0, 0, 1, 0); tick();
    set_in(1, 0, 1, 0, 0); tick();
    set_in(0, 0, 0, 1, 1);
    #1;
    total++;
    if (stkz_resp_valid_o !== 1'b1 || stkz_resp_err_o !== 1'b1 || core_resp_err_o !== 1'b0) begin
      bad++; $display("FAIL inter_err2: got sv=%b se=%b ce=%b want 1 1 0",
                      stkz_resp_valid_o, stkz_resp_err_o, core_resp_err_o);
    end
    tick();
    set_in(0, 0, 0, 1, 0);
    #1;
    total++;
    if (core_resp_valid_o !== 1'b1 || core_resp_err_o !== 1'b0 || stkz_resp_err_o !== 1'b0) begin
      bad++; $display("FAIL inter_resp3: got cv=%b ce=%b se=%b want 1 0 0",
                      core_resp_valid_o, core_resp_err_o, stkz_resp_err_o);
    end
    tick();
    lsu_resp_valid_i = 1'b0;
  endtask

  task automatic test_abort_spurious();
    do_reset();
    set_in(0, 1, 0, 0, 0);
    #1;
    total++;
    if (lsu_req_o !== 1'b1) begin
      bad++; $display("FAIL abort_grant: got %b want 1", lsu_req_o);
    end
    tick();
    set_in(1, 0, 0, 0, 0);
    #1;
    total++;
    if (lsu_req_o !== 1'b0 || stkz_req_done_o !== 1'b0) begin
      bad++; $display("FAIL abort_drop: got req=%b sdone=%b want 0 0", lsu_req_o, stkz_req_done_o);
    end
    tick();
    set_in(0, 0, 0, 1, 0);
    #1;
    total++;
    if (core_resp_valid_o !== 1'b0 || stkz_resp_valid_o !== 1'b0 || spurious_resp_o !== 1'b0) begin
      bad++; $display("FAIL abort_empty_resp: got cv=%b sv=%b sp=%b want 0 0 0",
                      core_resp_valid_o, stkz_resp_valid_o, spurious_resp_o);
    end
    tick();
    lsu_resp_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (spurious_resp_o !== 1'b1) begin
        bad++; $display("FAIL spurious_sticky[%0d]: got %b want 1", i, spurious_resp_o);
      end
      tick();
    end
    rst_ni = 1'b0;
    #1;
    total++;
    if (spurious_resp_o !== 1'b0) begin
      bad++; $display("FAIL spurious_reset: got %b want 0", spurious_resp_o);
    end
    rst_ni = 1'b1;
    mq.delete();
    mlock = 0; mstarve = 0; mspur = 0;
  endtask

  task automatic test_random();
    bit g, s, hv, h, hold_core;
    logic [9:0]  act, exp;
    logic [31:0] ea;
    logic [32:0] ew;
    do_reset();
    hold_core = 1'b0;
    for (int n = 0; n < 600; n++) begin
      core_req_i       = hold_core | ($urandom_range(0, 2) == 0);
      stkz_req_i       = $urandom_range(0, 1);
      lsu_req_done_i   = $urandom_range(0, 1);
      lsu_resp_valid_i = (mq.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 60) == 0);
      lsu_resp_err_i   = $urandom_range(0, 1);
      core_we_i = $urandom_range(0, 1); core_is_cap_i = $urandom_range(0, 1);
      stkz_we_i = $urandom_range(0, 1); stkz_is_cap_i = $urandom_range(0, 1);
      core_addr_i  = $urandom(); core_wdata_i = {1'($urandom_range(0, 1)), $urandom()};
      stkz_addr_i  = $urandom(); stkz_wdata_i = {1'($urandom_range(0, 1)), $urandom()};
      #1;
      mdl_eval(g, s);
      hv = lsu_resp_valid_i && (mq.size() > 0);
      h  = hv ? mq[0] : 1'b0;
      ea = g ? (s ? stkz_addr_i : core_addr_i) : 32'h0;
      ew = g ? (s ? stkz_wdata_i : core_wdata_i) : 33'h0;
      exp = {g, g & (s ? stkz_we_i : core_we_i), g & (s ? stkz_is_cap_i : core_is_cap_i),
             g & !s & lsu_req_done_i, g & s & lsu_req_done_i,
             hv & !h, hv & !h & lsu_resp_err_i, hv & h, hv & h & lsu_resp_err_i, mspur};
      act = {lsu_req_o, lsu_we_o, lsu_is_cap_o, core_req_done_o, stkz_req_done_o,
             core_resp_valid_o, core_resp_err_o, stkz_resp_valid_o, stkz_resp_err_o, spurious_resp_o};
      total++;
      if (act !== exp) begin
        bad++; $display("FAIL rand_ctrl[%0d]: got %b want %b", n, act, exp);
      end
      total++;
      if (lsu_addr_o !== ea) begin
        bad++; $display("FAIL rand_addr[%0d]: got %h want %h", n, lsu_addr_o, ea);
      end
      total++;
      if (lsu_wdata_o !== ew) begin
        bad++; $display("FAIL rand_wdata[%0d]: got %h want %h", n, lsu_wdata_o, ew);
      end
      hold_core = core_req_i && !(g && !s && lsu_req_done_i);
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_core_only();
    test_starve();
    test_lock_stkz();
    test_full();
    test_interleave();
    test_abort_spurious();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
